sort_frame_collector: RTL and testbench
=======================================

Name: sort_frame_collector

Overview:
- Downstream of the 4-input serial compare-and-swap sorter.
- Consumes its serial sorted stream (largest first), one signed word per beat.
- Reassembles each frame of N words into a parallel bus and computes median and range.
- Presents the result on a valid/ready output register with overrun detection.

Parameters:
- DW, 5, word width (signed two's complement)
- N, 4, words per frame (even, >=2)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  DW  signed sorted word from the sorter
- din_valid  input  1  din is a valid beat this cycle
- din_first  input  1  with din_valid: this beat is rank 0 (maximum) of a new frame
- out_ready  input  1  consumer accepts the held result
- out_valid  output  1  result registers hold an unconsumed frame
- sorted_bus  output  N*DW  rank k at bits [k*DW +: DW], rank 0 = maximum
- median  output  DW  signed floor((rank N/2-1 + rank N/2)/2)
- range  output  DW+1  rank 0 minus rank N-1, DW+1-bit two's complement
- order_err  output  1  the held frame was not non-increasing
- overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset (async, rst_n low): state IDLE, idx=0, out_valid=0, every sorted_bus entry = -2^(DW-1) (-16 at DW=5), median=-16, range=0, order_err=0, overrun=0, capture buffer = -16.
- FSM states:
  - IDLE: beats without din_first are ignored.
  - IDLE, din_valid&din_first: capture din at rank 0, idx=1, go to COLLECT.
  - COLLECT, din_valid&!din_first: capture at rank idx, idx++.
  - COLLECT, din_valid&din_first: abort the partial frame, restart at rank 0 with idx=1. No error flag is raised.
  - COLLECT, !din_valid: hold. Gaps between beats are allowed.
  - Beat at idx=N-1 completes the frame: return to IDLE, idx=0.
- Order check:
  - A running flag is set if any captured word > previous captured word (signed).
  - The flag clears at each frame start.
- Completion transfer (result registers update on the edge after the last beat is sampled, latency 1):
  - If out_valid=0, or out_valid=1 and out_ready=1 in the completion cycle: load sorted_bus, median, range and order_err; out_valid=1.
  - If out_valid=1 and out_ready=0: keep the held result, drop the new frame, set overrun. overrun clears only on reset.
- Handshake:
  - Transfer occurs on out_valid&out_ready.
  - With no simultaneous completion, out_valid falls next cycle; data registers hold their last values.
  - All outputs stay stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - median: sign-extend both middle ranks to DW+1, add, arithmetic shift right 1, truncate to DW. Always representable.
  - range: sign-extend to DW+1, subtract. Non-negative for ordered frames. Raw two's complement when order_err=1.
- A new frame may begin on the cycle immediately after completion. Back-to-back frames need no idle cycle.
- Reset asserted mid-frame discards all partial and held data.

Test Plan:
- Frame 7,3,-2,-16 (first on 7), out_ready=1 -> out_valid one cycle after the -16 beat; sorted_bus ranks {7,3,-2,-16}, median 0, range 23, order_err 0.
- Frame 5,-1,-2,-8 -> median -2 ((-3)>>>1), range 13. Frame 15,15,-16,-16 -> median -1, range 31 (6'b011111).
- Two back-to-back frames with out_ready=0 -> first frame held unchanged, overrun=1. Then out_ready=1 -> out_valid drops next cycle, overrun stays 1 until reset.
- Beats 9,4 then din_first on 6 followed by 2,1,0 -> result {6,2,1,0}; the partial frame is discarded with no error.
- Frame 1,3,0,-4 -> order_err 1, range 5. Inject 2-cycle din_valid gaps inside a frame -> same result, latency measured from the last beat.
- rst_n pulsed low after 2 beats -> out_valid 0, bus all -16. The next full frame 0,0,0,0 -> median 0, range 0.

Source files
------------

// File: rtl/sort_frame_collector_if.sv
// Serial sorted-word input and parallel frame-result output
// of the sort frame collector.
interface sort_frame_collector_if #(
    parameter int DW = 5,
    parameter int N  = 4
);
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic                 din_first;
    logic                 out_ready;
    logic                 out_valid;
    logic [N*DW-1:0]      sorted_bus;
    logic signed [DW-1:0] median;
    logic signed [DW:0]   range;
    logic                 order_err;
    logic                 overrun;

    modport master (
        output din, din_valid, din_first, out_ready,
        input  out_valid, sorted_bus, median, range,
        input  order_err, overrun
    );

    modport slave (
        input  din, din_valid, din_first, out_ready,
        output out_valid, sorted_bus, median, range,
        output order_err, overrun
    );
endinterface

// File: rtl/sort_frame_collector.sv
// Reassembles a serial largest-first frame into a parallel bus
// and holds it with median and range on a valid/ready register.
module sort_frame_collector #(
    parameter int DW = 5,
    parameter int N  = 4
) (
    input logic clk,
    input logic rst_n,
    sort_frame_collector_if.slave io
);
    localparam int IW = $clog2(N);
    localparam logic signed [DW-1:0] MIN_W = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 err_q, err_d;
    logic signed [DW-1:0] cap_q [N];
    logic                 cap_en;
    logic [IW-1:0]        cap_idx;
    logic                 done;

    logic signed [DW-1:0] din_s;
    logic signed [DW-1:0] frame [N];
    logic [N*DW-1:0]      frame_bus;
    logic signed [DW:0]   mid_a, mid_b, top_w, bot_w;
    logic signed [DW-1:0] med_d;
    logic signed [DW:0]   rng_d;

    logic                 valid_q;
    logic [N*DW-1:0]      bus_q;
    logic signed [DW-1:0] med_q;
    logic signed [DW:0]   rng_q;
    logic                 oerr_q;
    logic                 ovr_q;

    assign din_s = io.din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cap_en  = 1'b0;
        cap_idx = idx_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.din_valid && io.din_first) begin
                    cap_en  = 1'b1;
                    cap_idx = '0;
                    idx_d   = IW'(1);
                    err_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (io.din_valid) begin
                    cap_en = 1'b1;
                    // A fresh maximum silently restarts the frame
                    if (io.din_first) begin
                        cap_idx = '0;
                        idx_d   = IW'(1);
                        err_d   = 1'b0;
                    end else begin
                        err_d = err_q | (din_s > cap_q[idx_q - IW'(1)]);
                        if (idx_q == IW'(N-1)) begin
                            done    = 1'b1;
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) cap_q[k] <= MIN_W;
        end else if (cap_en) begin
            cap_q[cap_idx] <= din_s;
        end
    end

    // Completing frame: buffered ranks plus the last beat still on din
    always_comb begin
        frame_bus = '0;
        for (int k = 0; k < N; k++) begin
            frame[k] = (k == N-1) ? din_s : cap_q[k];
            frame_bus[k*DW +: DW] = frame[k];
        end
    end

    assign mid_a = frame[N/2-1];
    assign mid_b = frame[N/2];
    assign top_w = frame[0];
    assign bot_w = frame[N-1];
    assign med_d = DW'((mid_a + mid_b) >>> 1);
    assign rng_d = top_w - bot_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            bus_q   <= {N{MIN_W}};
            med_q   <= MIN_W;
            rng_q   <= '0;
            oerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (done && (!valid_q || io.out_ready)) begin
            valid_q <= 1'b1;
            bus_q   <= frame_bus;
            med_q   <= med_d;
            rng_q   <= rng_d;
            oerr_q  <= err_d;
        end else begin
            if (done) ovr_q <= 1'b1;
            if (valid_q && io.out_ready) valid_q <= 1'b0;
        end
    end

    assign io.out_valid  = valid_q;
    assign io.sorted_bus = bus_q;
    assign io.median     = med_q;
    assign io.range      = rng_q;
    assign io.order_err  = oerr_q;
    assign io.overrun    = ovr_q;
endmodule

// File: tb/tb_sort_frame_collector.sv
// Directed bench for sort_frame_collector with hand-computed
// frame results (DW=5, N=4).
module tb_sort_frame_collector;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sort_frame_collector_if #(.DW(5), .N(4)) io();

    sort_frame_collector #(.DW(5), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rk(input int k);
        logic signed [4:0] t;
        t = io.sorted_bus[k*5 +: 5];
        return int'(t);
    endfunction

    task automatic beat(input int v, input logic first);
        io.din       = 5'(v);
        io.din_valid = 1'b1;
        io.din_first = first;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        io.din_valid = 1'b0;
        io.din_first = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_frame(input string tag,
                             input int e0, input int e1,
                             input int e2, input int e3,
                             input int emed, input int erng,
                             input int eerr);
        chk({tag, ".valid"}, int'(io.out_valid), 1);
        chk({tag, ".r0"}, rk(0), e0);
        chk({tag, ".r1"}, rk(1), e1);
        chk({tag, ".r2"}, rk(2), e2);
        chk({tag, ".r3"}, rk(3), e3);
        chk({tag, ".med"}, int'(io.median), emed);
        chk({tag, ".rng"}, int'(io.range), erng);
        chk({tag, ".oerr"}, int'(io.order_err), eerr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, int'(io.out_valid), 0);
        for (int k = 0; k < 4; k++) chk({tag, ".rk"}, rk(k), -16);
        chk({tag, ".med"}, int'(io.median), -16);
        chk({tag, ".rng"}, int'(io.range), 0);
        chk({tag, ".oerr"}, int'(io.order_err), 0);
        chk({tag, ".ovr"}, int'(io.overrun), 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        io.din       = '0;
        io.din_valid = 1'b0;
        io.din_first = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // basic frame, latency 1 from last beat
        beat(7, 1'b1);
        beat(3, 1'b0);
        beat(-2, 1'b0);
        chk("f1.pre", int'(io.out_valid), 0);
        beat(-16, 1'b0);
        chk_frame("f1", 7, 3, -2, -16, 0, 23, 0);
        idle(1);
        chk("f1.drop", int'(io.out_valid), 0);
        chk("f1.hold", int'(io.median), 0);

        // back-to-back frames with ready high
        beat(5, 1'b1);
        beat(-1, 1'b0);
        beat(-2, 1'b0);
        beat(-8, 1'b0);
        chk_frame("f2", 5, -1, -2, -8, -2, 13, 0);
        beat(15, 1'b1);
        chk("f2.drop", int'(io.out_valid), 0);
        beat(15, 1'b0);
        beat(-16, 1'b0);
        beat(-16, 1'b0);
        chk_frame("f3", 15, 15, -16, -16, -1, 31, 0);
        idle(1);

        // overrun: second frame dropped while first held
        io.out_ready = 1'b0;
        beat(4, 1'b1);
        beat(3, 1'b0);
        beat(2, 1'b0);
        beat(1, 1'b0);
        chk_frame("ovA", 4, 3, 2, 1, 2, 3, 0);
        chk("ovA.ovr", int'(io.overrun), 0);
        beat(10, 1'b1);
        beat(8, 1'b0);
        beat(6, 1'b0);
        beat(4, 1'b0);
        idle(1);
        chk_frame("ovB", 4, 3, 2, 1, 2, 3, 0);
        chk("ovB.ovr", int'(io.overrun), 1);
        io.out_ready = 1'b1;
        idle(1);
        chk("ov.drop", int'(io.out_valid), 0);
        chk("ov.sticky", int'(io.overrun), 1);

        // abort partial frame on a new first beat
        beat(9, 1'b1);
        beat(4, 1'b0);
        beat(6, 1'b1);
        beat(2, 1'b0);
        beat(1, 1'b0);
        beat(0, 1'b0);
        chk_frame("abort", 6, 2, 1, 0, 1, 6, 0);
        chk("abort.ovr", int'(io.overrun), 1);
        idle(2);

        // out-of-order frame
        beat(1, 1'b1);
        beat(3, 1'b0);
        beat(0, 1'b0);
        beat(-4, 1'b0);
        chk_frame("oerr", 1, 3, 0, -4, 1, 5, 1);
        idle(2);

        // gaps inside a frame; order flag cleared again
        beat(7, 1'b1);
        idle(2);
        beat(3, 1'b0);
        idle(2);
        beat(-2, 1'b0);
        idle(2);
        chk("gap.pre", int'(io.out_valid), 0);
        beat(-16, 1'b0);
        chk_frame("gap", 7, 3, -2, -16, 0, 23, 0);
        idle(2);

        // reset mid-frame
        beat(5, 1'b1);
        beat(4, 1'b0);
        io.din_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mrst");
        rst_n = 1'b1;
        @(negedge clk);
        beat(0, 1'b1);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        chk_frame("zero", 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
